bip_control: RTL and testbench

BIP_CONTROL -- requirements
Module: bip_control

---
 rtl/bip_control.sv | 123 ++++++++++++
 tb/tb_bip_control.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bip_control.sv
// Control unit for the BIP accumulator processor: FETCH/DECODE/EXEC sequencer
// that turns each 16-bit program word into datapath selects and one-cycle strobes.
module bip_control #(
    parameter int PC_WIDTH = 11
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [15:0]         Instr,
    output logic [PC_WIDTH-1:0] Addr_PM,
    output logic [PC_WIDTH-1:0] Addr_DM,
    output logic [1:0]          SelA,
    output logic                SelB,
    output logic                Op,
    output logic                WrAcc,
    output logic                WrRam,
    output logic                RdRam,
    output logic                Halted,
    output logic [15:0]         Ins_Count
);

    localparam logic [4:0] OP_HLT  = 5'b00000;
    localparam logic [4:0] OP_STO  = 5'b00001;
    localparam logic [4:0] OP_LD   = 5'b00010;
    localparam logic [4:0] OP_LDI  = 5'b00011;
    localparam logic [4:0] OP_ADD  = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_SUBI = 5'b00111;

    typedef enum logic [1:0] {
        FETCH  = 2'b00,
        DECODE = 2'b01,
        EXEC   = 2'b10,
        HALT   = 2'b11
    } state_t;

    state_t              state;
    logic [15:0]         ir;
    logic [PC_WIDTH-1:0] pc;

    function automatic logic reads_ram(input logic [4:0] op);
        return (op == OP_LD) || (op == OP_ADD) || (op == OP_SUB);
    endfunction

    function automatic logic writes_acc(input logic [4:0] op);
        return (op >= OP_LD) && (op <= OP_SUBI);
    endfunction

    function automatic logic [1:0] sel_a(input logic [4:0] op);
        if (op == OP_LDI)
            return 2'b01;
        else if ((op >= OP_ADD) && (op <= OP_SUBI))
            return 2'b10;
        else
            return 2'b00;
    endfunction

    function automatic logic sel_b(input logic [4:0] op);
        return (op == OP_ADDI) || (op == OP_SUBI);
    endfunction

    function automatic logic alu_sub(input logic [4:0] op);
        return (op == OP_SUB) || (op == OP_SUBI);
    endfunction

    // Operand address comes straight from IR so it is valid from DECODE onward
    assign Addr_PM = pc;
    assign Addr_DM = ir[PC_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FETCH;
            pc        <= '0;
            ir        <= '0;
            Ins_Count <= '0;
            Halted    <= 1'b0;
            WrAcc     <= 1'b0;
            WrRam     <= 1'b0;
            RdRam     <= 1'b0;
            SelA      <= 2'b00;
            SelB      <= 1'b0;
            Op        <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    // Selects and the read strobe are decoded from the incoming word so
                    // they are already stable for the whole DECODE cycle.
                    ir    <= Instr;
                    RdRam <= reads_ram(Instr[15:11]);
                    SelA  <= sel_a(Instr[15:11]);
                    SelB  <= sel_b(Instr[15:11]);
                    Op    <= alu_sub(Instr[15:11]);
                    state <= DECODE;
                end
                DECODE: begin
                    if (ir[15:11] == OP_HLT) begin
                        Halted <= 1'b1;
                        state  <= HALT;
                    end else begin
                        WrAcc <= writes_acc(ir[15:11]);
                        WrRam <= (ir[15:11] == OP_STO);
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    WrAcc     <= 1'b0;
                    WrRam     <= 1'b0;
                    RdRam     <= 1'b0;
                    pc        <= pc + 1'b1;
                    Ins_Count <= Ins_Count + 16'd1;
                    state     <= FETCH;
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bip_control.sv
// Directed bench for bip_control: small programs in a behavioural program memory,
// outputs sampled 1 time unit after each rising edge against hand-derived values.
module tb_bip_control;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] Instr;
    logic [10:0] Addr_PM;
    logic [10:0] Addr_DM;
    logic [1:0]  SelA;
    logic        SelB;
    logic        Op;
    logic        WrAcc;
    logic        WrRam;
    logic        RdRam;
    logic        Halted;
    logic [15:0] Ins_Count;

    logic [15:0] pmem [0:2047];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign Instr = pmem[Addr_PM];

    bip_control #(.PC_WIDTH(11)) dut (
        .clk(clk), .reset(reset), .Instr(Instr),
        .Addr_PM(Addr_PM), .Addr_DM(Addr_DM),
        .SelA(SelA), .SelB(SelB), .Op(Op),
        .WrAcc(WrAcc), .WrRam(WrRam), .RdRam(RdRam),
        .Halted(Halted), .Ins_Count(Ins_Count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_mem(input logic [15:0] w);
        for (int i = 0; i < 2048; i++) pmem[i] = w;
    endtask

    // After this returns the bench sits in cycle 1, the first FETCH.
    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        fill_mem(16'h0000);
        do_reset();
        checks++;
        if ({WrAcc, WrRam, RdRam, Halted} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_strobes: got %b expected 0000", {WrAcc, WrRam, RdRam, Halted});
        end
        checks++;
        if ({Addr_PM, Addr_DM, Ins_Count} !== 38'd0) begin
            errors++;
            $display("FAIL reset_regs: pc=%0d dm=%0d cnt=%0d expected 0 0 0", Addr_PM, Addr_DM, Ins_Count);
        end
        checks++;
        if ({SelA, SelB, Op} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_sel: got %b expected 0000", {SelA, SelB, Op});
        end
    endtask

    // LDI 5; ADDI -3; STO 0x010; HLT
    task automatic test_program();
        logic [3:0] exp;
        fill_mem(16'h0000);
        pmem[0] = {5'b00011, 11'd5};
        pmem[1] = {5'b00101, 11'h7FD};
        pmem[2] = {5'b00001, 11'h010};
        pmem[3] = {5'b00000, 11'h000};
        do_reset();
        for (int c = 1; c <= 16; c++) begin
            exp = {(c == 3 || c == 6), (c == 9), 1'b0, (c >= 12)};
            if (c != 11) begin
                checks++;
                if ({WrAcc, WrRam, RdRam, Halted} !== exp) begin
                    errors++;
                    $display("FAIL prog_strobes c%0d: got %b expected %b", c, {WrAcc, WrRam, RdRam, Halted}, exp);
                end
            end
            if (c == 3) begin
                checks++;
                if (SelA !== 2'b01) begin
                    errors++;
                    $display("FAIL prog_ldi_sela: got %b expected 01", SelA);
                end
            end
            if (c == 6) begin
                checks++;
                if ({SelA, SelB, Op} !== 4'b1010) begin
                    errors++;
                    $display("FAIL prog_addi_sel: got %b expected 1010", {SelA, SelB, Op});
                end
            end
            if (c == 9) begin
                checks++;
                if (Addr_DM !== 11'h010) begin
                    errors++;
                    $display("FAIL prog_sto_addr: got %h expected 010", Addr_DM);
                end
            end
            step();
        end
        checks++;
        if (Ins_Count !== 16'd3 || Addr_PM !== 11'd3) begin
            errors++;
            $display("FAIL prog_final: cnt=%0d pc=%0d expected 3 3", Ins_Count, Addr_PM);
        end
    endtask

    // LD 0x020; SUB 0x021
    task automatic test_ld_sub();
        logic [1:0] exp;
        fill_mem(16'h0000);
        pmem[0] = {5'b00010, 11'h020};
        pmem[1] = {5'b00110, 11'h021};
        do_reset();
        for (int c = 1; c <= 6; c++) begin
            exp = {(c == 3 || c == 6), (c == 2 || c == 3 || c == 5 || c == 6)};
            checks++;
            if ({WrAcc, RdRam} !== exp || WrRam !== 1'b0) begin
                errors++;
                $display("FAIL ldsub_strobes c%0d: wracc/rdram=%b wrram=%b expected %b/0", c, {WrAcc, RdRam}, WrRam, exp);
            end
            if (c == 2 || c == 3) begin
                checks++;
                if (Addr_DM !== 11'h020 || SelA !== 2'b00) begin
                    errors++;
                    $display("FAIL ld_addr c%0d: dm=%h sela=%b expected 020 00", c, Addr_DM, SelA);
                end
            end
            if (c == 5 || c == 6) begin
                checks++;
                if (Addr_DM !== 11'h021 || {SelA, SelB, Op} !== 4'b1001) begin
                    errors++;
                    $display("FAIL sub_addr c%0d: dm=%h sel=%b expected 021 1001", c, Addr_DM, {SelA, SelB, Op});
                end
            end
            step();
        end
    endtask

    task automatic test_nop();
        fill_mem(16'h0000);
        pmem[0] = 16'hF800;
        do_reset();
        for (int c = 1; c <= 3; c++) begin
            checks++;
            if ({WrAcc, WrRam, RdRam, Halted} !== 4'b0000) begin
                errors++;
                $display("FAIL nop_strobes c%0d: got %b expected 0000", c, {WrAcc, WrRam, RdRam, Halted});
            end
            step();
        end
        checks++;
        if (Addr_PM !== 11'd1 || Ins_Count !== 16'd1) begin
            errors++;
            $display("FAIL nop_final: pc=%0d cnt=%0d expected 1 1", Addr_PM, Ins_Count);
        end
    endtask

    task automatic test_pc_wrap();
        fill_mem(16'h4000);
        do_reset();
        repeat (2047 * 3) step();
        checks++;
        if (Addr_PM !== 11'd2047 || Ins_Count !== 16'd2047) begin
            errors++;
            $display("FAIL wrap_pre: pc=%0d cnt=%0d expected 2047 2047", Addr_PM, Ins_Count);
        end
        repeat (3) step();
        checks++;
        if (Addr_PM !== 11'd0 || Ins_Count !== 16'd2048) begin
            errors++;
            $display("FAIL wrap_post: pc=%0d cnt=%0d expected 0 2048", Addr_PM, Ins_Count);
        end
    endtask

    task automatic test_reset_in_exec();
        fill_mem(16'h0000);
        pmem[0] = {5'b00001, 11'h010};
        pmem[1] = {5'b00001, 11'h011};
        do_reset();
        step();
        step();
        checks++;
        if (WrRam !== 1'b1) begin
            errors++;
            $display("FAIL rexec_sto: wrram=%b expected 1", WrRam);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if ({WrAcc, WrRam, RdRam} !== 3'b000 || Addr_PM !== 11'd0 || Ins_Count !== 16'd0) begin
            errors++;
            $display("FAIL rexec_after: strobes=%b pc=%0d cnt=%0d expected 000 0 0", {WrAcc, WrRam, RdRam}, Addr_PM, Ins_Count);
        end
        step();
        step();
        checks++;
        if (WrRam !== 1'b1 || Addr_DM !== 11'h010) begin
            errors++;
            $display("FAIL rexec_restart: wrram=%b dm=%h expected 1 010", WrRam, Addr_DM);
        end
    endtask

    // LDI 1; HLT -> HALT entered in cycle 6
    task automatic test_halt_hold();
        fill_mem(16'h0000);
        pmem[0] = {5'b00011, 11'd1};
        do_reset();
        repeat (5) step();
        for (int k = 0; k < 20; k++) begin
            checks++;
            if ({WrAcc, WrRam, RdRam, Halted} !== 4'b0001 || Addr_PM !== 11'd1 || Ins_Count !== 16'd1) begin
                errors++;
                $display("FAIL halt_hold k%0d: strobes=%b pc=%0d cnt=%0d expected 0001 1 1", k, {WrAcc, WrRam, RdRam, Halted}, Addr_PM, Ins_Count);
            end
            step();
        end
        do_reset();
        checks++;
        if (Halted !== 1'b0 || Addr_PM !== 11'd0 || Ins_Count !== 16'd0) begin
            errors++;
            $display("FAIL halt_reset: halted=%b pc=%0d cnt=%0d expected 0 0 0", Halted, Addr_PM, Ins_Count);
        end
        step();
        step();
        checks++;
        if (WrAcc !== 1'b1 || SelA !== 2'b01) begin
            errors++;
            $display("FAIL halt_resume: wracc=%b sela=%b expected 1 01", WrAcc, SelA);
        end
    endtask

    initial begin
        test_reset();
        test_program();
        test_ld_sub();
        test_nop();
        test_pc_wrap();
        test_reset_in_exec();
        test_halt_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
